masked_quad_pipe: RTL



---
 rtl/masked_quad_pipe.sv | 75 +++++++
 1 files changed

// File: rtl/masked_quad_pipe.sv
// masked_quad_pipe: two-stage masked evaluation of a^(b&d) and b^(c&d) with refreshed cross-share terms
module masked_quad_pipe #(
  parameter int SHARES = 3,
  parameter int WIDTH = 4,
  localparam int RAND_W = 2*WIDTH*SHARES*(SHARES-1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic                     rnd_valid,
  input  logic [SHARES*WIDTH-1:0]  a,
  input  logic [SHARES*WIDTH-1:0]  b,
  input  logic [SHARES*WIDTH-1:0]  c,
  input  logic [SHARES*WIDTH-1:0]  d,
  input  logic [RAND_W-1:0]        r,
  output logic [SHARES*WIDTH-1:0]  q_bd,
  output logic [SHARES*WIDTH-1:0]  q_cd,
  output logic                     out_valid,
  output logic                     rnd_err
);
  localparam int R = SHARES*(SHARES-1);
  localparam int HALF = WIDTH*R;
  logic [SHARES-1:0][SHARES-1:0][WIDTH-1:0] n_bd, n_cd, t_bd, t_cd;
  logic [SHARES-1:0][WIDTH-1:0] s_bd, s_cd;
  logic v1, accept;
  assign accept = en & in_valid & rnd_valid;
  // Stage-1 terms: slot 0 is the own-share product, slot m pairs share i with share (i+m) under ring refresh
  always_comb begin
    n_bd = '0;
    n_cd = '0;
    for (int i = 0; i < SHARES; i++)
      for (int w = 0; w < WIDTH; w++) begin
        n_bd[i][0][w] = a[i*WIDTH+w] ^ (b[i*WIDTH+w] & d[i*WIDTH+w]);
        n_cd[i][0][w] = b[i*WIDTH+w] ^ (c[i*WIDTH+w] & d[i*WIDTH+w]);
        for (int m = 1; m < SHARES; m++) begin
          n_bd[i][m][w] = (b[((i+m)%SHARES)*WIDTH+w] & d[i*WIDTH+w])
                        ^ r[w*R + i*(SHARES-1) + m-1] ^ r[w*R + (i*(SHARES-1)+m)%R];
          n_cd[i][m][w] = (c[((i+m)%SHARES)*WIDTH+w] & d[i*WIDTH+w])
                        ^ r[HALF + w*R + i*(SHARES-1) + m-1] ^ r[HALF + w*R + (i*(SHARES-1)+m)%R];
        end
      end
  end
  // Stage-2 compression: each output share folds its registered terms
  always_comb begin
    s_bd = '0;
    s_cd = '0;
    for (int i = 0; i < SHARES; i++)
      for (int m = 0; m < SHARES; m++) begin
        s_bd[i] = s_bd[i] ^ t_bd[i][m];
        s_cd[i] = s_cd[i] ^ t_cd[i][m];
      end
  end
  // Pipeline registers; terms load only on accept, everything freezes when en is low
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      t_bd <= '0;
      t_cd <= '0;
      v1 <= 1'b0;
      q_bd <= '0;
      q_cd <= '0;
      out_valid <= 1'b0;
      rnd_err <= 1'b0;
    end else if (en) begin
      v1 <= accept;
      out_valid <= v1;
      q_bd <= s_bd;
      q_cd <= s_cd;
      if (accept) begin
        t_bd <= n_bd;
        t_cd <= n_cd;
      end
      if (in_valid && !rnd_valid) rnd_err <= 1'b1;
    end
endmodule
